// File: rtl/rom_addr_seq.sv
//------------------------------------------------------------------------------
// rom_addr_seq
//   Key-driven ROM address sequencer feeding an 8x256 ROM read path.
//   Steps addr on a fixed tick (up or down, with wrap), key1 toggles RUN/HOLD,
//   key2 toggles direction.  addr_upd marks each new address; data_vld is
//   addr_upd delayed by the ROM read latency.
//   Optional feature macro: ROM_SEQ_STEP_EN -- in HOLD, key2 steps addr once
//   in the current direction instead of toggling dir.
//------------------------------------------------------------------------------
`default_nettype none

module rom_addr_seq #(
  parameter logic [22:0]       CNT_MAX  = 23'd4_999_999,
  parameter int unsigned       ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}},
  parameter int unsigned       RD_LAT   = 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              key1_flag,
  input  logic              key2_flag,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_upd,
  output logic              data_vld,
  output logic              dir,
  output logic              running
);

  localparam logic [0:0]        S_RUN    = 1'b0;
  localparam logic [0:0]        S_HOLD   = 1'b1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [0:0]        state;
  logic [0:0]        state_nxt;
  logic [22:0]       cnt;
  logic [22:0]       cnt_nxt;
  logic              init_done;
  logic [RD_LAT-1:0] vld_sr;

  logic [ADDR_W-1:0] addr_up;
  logic [ADDR_W-1:0] addr_dn;
  logic [ADDR_W-1:0] addr_step;
  logic              tick;
  logic              run_step;
  logic              man_step;
  logic              do_step;
  logic              dir_tgl;

  // Wrap-aware neighbours of addr; wrap is an explicit compare against ADDR_MAX
  // so a non power-of-two range works the same as the full range.
  always_comb begin
    addr_up   = (addr == ADDR_MAX) ? '0 : (addr + ADDR_ONE);
    addr_dn   = (addr == '0) ? ADDR_MAX : (addr - ADDR_ONE);
    addr_step = dir ? addr_dn : addr_up;
  end

  // Step / direction decisions.  key1 on the tick cycle suppresses the step.
  always_comb begin
    tick     = (cnt == CNT_MAX);
    run_step = init_done && (state == S_RUN) && !key1_flag && tick;
`ifdef ROM_SEQ_STEP_EN
    // In HOLD key2 becomes a single manual step; dir only toggles in RUN.
    man_step = init_done && (state == S_HOLD) && key2_flag;
    dir_tgl  = key2_flag && (state == S_RUN);
`else
    man_step = 1'b0;
    dir_tgl  = key2_flag;
`endif
    do_step  = run_step || man_step;
  end

  // Next-state for the RUN/HOLD machine and the tick counter.  The counter
  // stays at 0 during the init-pulse cycle so the first step lands
  // CNT_MAX+1 clocks after the init pulse.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (key1_flag) begin
      state_nxt = (state == S_RUN) ? S_HOLD : S_RUN;
    end
    if (!init_done || key1_flag || (state == S_HOLD) || tick) begin
      cnt_nxt = '0;
    end else begin
      cnt_nxt = cnt + 23'd1;
    end
  end

  // Main registers: state, counter, direction, address and update pulse.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= S_RUN;
      cnt       <= '0;
      dir       <= 1'b0;
      addr      <= '0;
      addr_upd  <= 1'b0;
      init_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      dir       <= dir ^ dir_tgl;
      init_done <= 1'b1;
      addr_upd  <= !init_done || do_step;
      if (do_step) begin
        addr <= addr_step;
      end
    end
  end

  // data_vld delay line: addr_upd shifted RD_LAT clocks, independent of state.
  generate
    if (RD_LAT == 1) begin : g_lat1
      always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
          vld_sr <= '0;
        end else begin
          vld_sr[0] <= addr_upd;
        end
      end
    end else begin : g_latn
      always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
          vld_sr <= '0;
        end else begin
          vld_sr <= {vld_sr[RD_LAT-2:0], addr_upd};
        end
      end
    end
  endgenerate

  assign data_vld = vld_sr[RD_LAT-1];
  assign running  = (state == S_RUN);

endmodule

`default_nettype wire
